// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: watches two lamp heads for encoding, conflict, sequence and dwell faults.
// Define MONITOR_FLASH_EN to make flash_red blink every FLASH_HALF cycles in FAULT instead of holding 1.
module traffic_light_monitor #(
    parameter int MIN_GREEN  = 10,
    parameter int MIN_YELLOW = 3,
    parameter int MAX_DWELL  = 40,
    parameter int FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] NS_light,
    input  logic [2:0] EW_light,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash_red,
    output logic [7:0] cycle_count
);
    typedef enum logic [1:0] {INIT, RUN, FAULT} state_t;
    localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;
    state_t     st;
    logic [1:0] pat;
    logic [7:0] dwell;
    logic [7:0] flash_cnt;
    logic       first;
    logic       gr, yr, rg, ry, legal, run, hold, succ, enc_bad, conf_bad, short_bad, flash_wrap;
    logic [1:0] pidx;
    logic [2:0] code;
    always_comb begin
        gr = NS_light == GRN && EW_light == RED;
        yr = NS_light == YEL && EW_light == RED;
        rg = NS_light == RED && EW_light == GRN;
        ry = NS_light == RED && EW_light == YEL;
        legal = gr | yr | rg | ry;
        pidx = gr ? 2'd0 : yr ? 2'd1 : rg ? 2'd2 : 2'd3;
        run = st == RUN;
        hold = legal && pidx == pat;
        succ = legal && pidx == pat + 2'd1;
        enc_bad = !$onehot(NS_light) || !$onehot(EW_light);
        conf_bad = NS_light != RED && EW_light != RED;
        // pattern index bit 0 marks the yellow phases (YR, RY)
        short_bad = succ && !first && (pat[0] ? dwell < 8'(MIN_YELLOW) : dwell < 8'(MIN_GREEN));
        code = (st == FAULT) ? 3'd0 :
               enc_bad ? 3'd1 :
               conf_bad ? 3'd2 :
               (run && !hold && !succ) ? 3'd3 :
               (run && short_bad) ? 3'd4 :
               (run && hold && dwell == 8'(MAX_DWELL)) ? 3'd5 : 3'd0;
        flash_wrap = flash_cnt == 8'(FLASH_HALF - 1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= INIT;
            fault       <= 1'b0;
            fault_code  <= 3'd0;
            flash_red   <= 1'b0;
            cycle_count <= 8'd0;
            dwell       <= 8'd0;
            flash_cnt   <= 8'd0;
            pat         <= 2'd0;
            first       <= 1'b0;
        end else if (code != 3'd0) begin
            st         <= FAULT;
            fault      <= 1'b1;
            fault_code <= code;
            flash_red  <= 1'b1;
            flash_cnt  <= 8'd0;
        end else begin
            case (st)
                INIT: if (legal) begin
                    st    <= RUN;
                    pat   <= pidx;
                    dwell <= 8'd1;
                    first <= 1'b1;
                end
                RUN: if (succ) begin
                    pat   <= pidx;
                    dwell <= 8'd1;
                    first <= 1'b0;
                    if (pat == 2'd3) cycle_count <= cycle_count + 8'd1;
                end else begin
                    dwell <= (dwell == 8'hFF) ? dwell : dwell + 8'd1;
                end
                FAULT: if (fault_clr) begin
                    st         <= INIT;
                    fault      <= 1'b0;
                    fault_code <= 3'd0;
                    flash_red  <= 1'b0;
                    dwell      <= 8'd0;
                    flash_cnt  <= 8'd0;
                end else begin
                    flash_cnt <= flash_wrap ? 8'd0 : flash_cnt + 8'd1;
`ifdef MONITOR_FLASH_EN
                    flash_red <= flash_wrap ? ~flash_red : flash_red;
`else
                    flash_red <= 1'b1;
`endif
                end
                default: st <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed vector table plus hand sequences for dwell, stuck, flash and reset.
module tb_traffic_light_monitor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] ns = 3'b100, ew = 3'b100;
    logic       fault_clr = 1'b0;
    logic       fault, flash_red;
    logic [2:0] fault_code;
    logic [7:0] cycle_count;
    int         checks = 0, failures = 0;

    localparam logic [5:0] GR = 6'b001_100, YR = 6'b010_100, RG = 6'b100_001, RY = 6'b100_010;
    localparam logic [5:0] RR = 6'b100_100, GG = 6'b001_001, EN = 6'b011_001;

    traffic_light_monitor dut (
        .clk(clk), .rst(rst), .NS_light(ns), .EW_light(ew), .fault_clr(fault_clr),
        .fault(fault), .fault_code(fault_code), .flash_red(flash_red), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] in;
        logic       clr;
        logic       ef;
        logic [2:0] ec;
        logic       efl;
        logic [7:0] ecc;
    } vec_t;
    vec_t tbl[18];

    task automatic step(input logic [5:0] p, input logic c, input logic r);
        ns = p[5:3];
        ew = p[2:0];
        fault_clr = c;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic f, input logic [2:0] c, input logic fl, input logic [7:0] cc);
        chk({nm, ".fault"}, {7'd0, fault}, {7'd0, f});
        chk({nm, ".code"}, {5'd0, fault_code}, {5'd0, c});
        chk({nm, ".flash"}, {7'd0, flash_red}, {7'd0, fl});
        chk({nm, ".cycles"}, cycle_count, cc);
    endtask

    initial begin
        logic exp_fl[7];
        tbl[0]  = '{GG, 0, 1, 2, 1, 2};
        tbl[1]  = '{GR, 0, 1, 2, 1, 2};
        tbl[2]  = '{RR, 0, 1, 2, 1, 2};
        tbl[3]  = '{EN, 1, 0, 0, 0, 2};
        tbl[4]  = '{RR, 0, 0, 0, 0, 2};
        tbl[5]  = '{EN, 0, 1, 1, 1, 2};
        tbl[6]  = '{GR, 1, 0, 0, 0, 2};
        tbl[7]  = '{RY, 0, 0, 0, 0, 2};
        tbl[8]  = '{RY, 1, 0, 0, 0, 2};
        tbl[9]  = '{GR, 0, 0, 0, 0, 3};
        tbl[10] = '{GR, 0, 0, 0, 0, 3};
        tbl[11] = '{GR, 0, 0, 0, 0, 3};
        tbl[12] = '{GR, 0, 0, 0, 0, 3};
        tbl[13] = '{GR, 0, 0, 0, 0, 3};
        tbl[14] = '{YR, 0, 1, 4, 1, 3};
        tbl[15] = '{RR, 1, 0, 0, 0, 3};
        tbl[16] = '{GR, 0, 0, 0, 0, 3};
        tbl[17] = '{RG, 0, 1, 3, 1, 3};

        step(RR, 0, 1);
        chk_all("reset", 0, 0, 0, 0);

        step(RR, 0, 0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 11; i++) begin
                step(GR, 0, 0);
                if (r == 2 && i == 0) chk("third_gr_cycles", cycle_count, 8'd2);
            end
            for (int i = 0; i < 4; i++) step(YR, 0, 0);
            for (int i = 0; i < 11; i++) step(RG, 0, 0);
            for (int i = 0; i < 4; i++) step(RY, 0, 0);
            chk($sformatf("legal_round%0d_fault", r), {7'd0, fault}, 8'd0);
        end
        chk("legal_cycles", cycle_count, 8'd2);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].in, tbl[i].clr, 0);
            chk_all($sformatf("vec%0d", i), tbl[i].ef, tbl[i].ec, tbl[i].efl, tbl[i].ecc);
        end

        step(GR, 1, 0);
        chk("stuck_clr_fault", {7'd0, fault}, 8'd0);
        for (int i = 0; i < 40; i++) step(GR, 0, 0);
        chk("stuck_40_fault", {7'd0, fault}, 8'd0);
        step(GR, 0, 0);
        chk_all("stuck_41", 1, 5, 1, 3);
`ifdef MONITOR_FLASH_EN
        exp_fl = '{1, 1, 1, 0, 0, 0, 0};
`else
        exp_fl = '{1, 1, 1, 1, 1, 1, 1};
`endif
        for (int i = 0; i < 7; i++) begin
            step(RG, 0, 0);
            chk($sformatf("flash%0d", i + 1), {7'd0, flash_red}, {7'd0, exp_fl[i]});
        end
        chk("stuck_code_hold", {5'd0, fault_code}, 8'd5);
        step(GR, 1, 0);
        chk_all("flash_clr", 0, 0, 0, 3);

        step(GR, 0, 0);
        step(GR, 0, 0);
        step(GR, 0, 1);
        chk_all("rst_mid_run", 0, 0, 0, 0);
        step(GG, 0, 0);
        chk_all("init_conflict", 1, 2, 1, 0);
        step(GG, 1, 1);
        chk_all("rst_in_fault", 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter MIN_GREEN, default 10: minimum legal green dwell, in cycles.
REQ-002 Parameter MIN_YELLOW, default 3: minimum legal yellow dwell, in cycles.
REQ-003 Parameter MAX_DWELL, default 40: maximum dwell of any pattern before a stuck fault, in cycles.
REQ-004 Parameter FLASH_HALF, default 4: half-period of the fault flash, in cycles.
REQ-005 Port: clk  in  1  system clock; all logic on its rising edge.
REQ-006 Port: rst  in  1  reset; synchronous, active-high.
REQ-007 Port: NS_light  in  3  North-South lamp, one-hot {red,yellow,green} = 100/010/001.
REQ-008 Port: EW_light  in  3  East-West lamp, same encoding.
REQ-009 Port: fault_clr  in  1  clears a latched fault.
REQ-010 Port: fault  out  1  sticky fault flag.
REQ-011 Port: fault_code  out  3  first-fault cause: 0 none, 1 encoding, 2 conflict, 3 illegal transition, 4 short dwell, 5 stuck.
REQ-012 Port: flash_red  out  1  fail-safe request to the lamp drivers.
REQ-013 Port: cycle_count  out  8  count of completed signal cycles.

Function
REQ-014 The FSM SHALL have exactly 3 states: INIT, RUN and FAULT.
REQ-015 Pattern definitions: GR = NS green/EW red, YR = NS yellow/EW red, RG = NS red/EW green, RY = NS red/EW yellow.
- Legal sequence: GR->YR->RG->RY->GR.
- Holding the same pattern is legal.
REQ-016 Checks SHALL be applied to the current inputs, with the result registered on the same rising edge. A violating input is therefore reflected on fault and fault_code one clock after it appears.
REQ-017 Encoding check: any lamp not exactly one-hot SHALL give code 1. Applies in INIT and RUN.
REQ-018 Conflict check: both lamps non-red SHALL give code 2. Applies in INIT and RUN.
REQ-019 Transition check, RUN only: any pattern other than the current pattern or its legal successor SHALL give code 3. This includes red/red.
REQ-020 Dwell counter:
- 8-bit, saturates at 255.
- Set to 1 when a new pattern is sampled; increments while the pattern holds.
REQ-021 Short-dwell check, RUN only: on leaving a green pattern with dwell < MIN_GREEN, or a yellow pattern with dwell < MIN_YELLOW, the monitor SHALL give code 4.
- The first phase after INIT is exempt.
REQ-022 Stuck check, RUN only: dwell reaching MAX_DWELL+1 SHALL give code 5.
REQ-023 Simultaneous violations: the lowest code number SHALL win.
- Only the first fault is latched.
- fault_code holds until cleared.
REQ-024 INIT SHALL move to RUN, with dwell = 1, on the first sample that is one of the 4 legal patterns.
- Red/red in INIT SHALL be ignored.
REQ-025 Any violation SHALL move the FSM to FAULT and set fault = 1.
- FAULT SHALL persist regardless of inputs.
REQ-026 fault_clr in FAULT SHALL return the FSM to INIT and set fault = 0, fault_code = 0, dwell = 0 and flash_red = 0.
- fault_clr SHALL have priority over any violation sampled on the same edge.
- fault_clr outside FAULT SHALL have no effect.
REQ-027 cycle_count SHALL increment on each legal RY->GR transition in RUN, and SHALL wrap from 255 to 0.

Reset
REQ-028 When rst = 1 at a rising edge, the block SHALL:
- enter INIT;
- set fault = 0, fault_code = 0, flash_red = 0 and cycle_count = 0;
- clear the dwell counter and flash counter.
REQ-029 rst SHALL have priority over fault_clr and over all checks, including mid-fault and mid-phase.

Configuration
REQ-030 Macro MONITOR_FLASH_EN:
- Defined: in FAULT, flash_red SHALL toggle every FLASH_HALF cycles, starting at 1 on the edge that enters FAULT.
- Undefined: flash_red SHALL be a steady 1 in FAULT.
- In both cases flash_red SHALL be 0 outside FAULT.

Verification
REQ-031 Legal sequence with dwells GR 11, YR 4, RG 11, RY 4, repeated 3 times -> fault stays 0; cycle_count = 2 after the third GR entry.
REQ-032 In RUN, apply NS = 001 and EW = 001 -> next edge gives fault = 1, fault_code = 2; the code holds when the inputs return to legal.
REQ-033 Apply NS = 011 while EW = 001 (encoding and conflict together) -> fault_code = 1.
REQ-034 GR held 5 cycles, then YR -> fault_code = 4; skip from GR to RG -> fault_code = 3.
REQ-035 Hold GR for 41 cycles -> fault_code = 5. With MONITOR_FLASH_EN defined, flash_red reads 1,1,1,1,0,0,0,0 from FAULT entry; undefined, it stays at 1.
REQ-036 Assert fault_clr together with a new violation -> INIT, fault = 0. Assert rst mid-RUN -> all outputs 0 on the next edge.
